// File: rtl/mem_responder.sv
// Single-port synchronous memory responder with a power-on/requested clear sweep.
// Optional parity storage and checking is enabled by defining MEM_RESPONDER_PARITY_EN.
module mem_responder #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  input  logic                  clear,
  output logic                  busy,
  output logic                  parity_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH - 1);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Bus semantics: read/write are single-cycle requests sampled at posedge and
  // accepted only in IDLE without clear; there is no stall, a busy cycle drops them.
  // read&write writes and returns data_in; a plain read returns data one cycle later.
  logic                  idle_req;
  logic                  acc_write;
  logic                  acc_read;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  always_comb begin
    idle_req  = (state == ST_IDLE) && !clear && !rst;
    acc_write = idle_req && write;
    acc_read  = idle_req && read && !write;
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = data_in;
    if (!rst) begin
      if (state == ST_CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = ptr;
        mem_wdata = '0;
      end else if (acc_write) begin
        mem_we = 1'b1;
      end
    end
  end

  assign busy = (state == ST_CLEAR);

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_CLEAR;
      ptr      <= '0;
      data_out <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        ST_CLEAR: begin
          // Pointer leaves through the state exit, never by wrapping.
          if (ptr == PTR_LAST) begin
            state <= ST_IDLE;
            ptr   <= '0;
          end else begin
            ptr <= ptr + ADDR_WIDTH'(1);
          end
        end
        default: begin
          if (clear) begin
            state <= ST_CLEAR;
            ptr   <= '0;
          end else if (acc_write && read) begin
            data_out <= data_in;
            rd_valid <= 1'b1;
          end else if (acc_read) begin
            data_out <= mem[addr];
            rd_valid <= 1'b1;
          end
        end
      endcase
    end
  end

`ifdef MEM_RESPONDER_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (mem_we) par_mem[mem_waddr] <= (state == ST_CLEAR) ? 1'b0 : ^data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err <= 1'b0;
    end else if (acc_write && read) begin
      parity_err <= 1'b0;
    end else if (acc_read) begin
      parity_err <= par_mem[addr] != ^mem[addr];
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Single-port synchronous memory that acts as the responder for the read/write/addr/data_in/data_out memory bus driven by the memory testbenches.
- After reset, and on request, a sequencer walks the full address space and zeroes it.
- Serves one read or write per cycle with a registered read port.
- Sits behind any bus initiator, and is the DUT for the memory bench.

Parameters:
ADDR_WIDTH, 5, address bits; depth = 2**ADDR_WIDTH words
DATA_WIDTH, 8, word width in bits

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
read  input  1  read request, sampled at posedge
write  input  1  write request, sampled at posedge
addr  input  ADDR_WIDTH  word address
data_in  input  DATA_WIDTH  write data
data_out  output  DATA_WIDTH  registered read data
rd_valid  output  1  one-cycle pulse: data_out updated by accepted read
clear  input  1  request full-array zeroing
busy  output  1  high while clear sequencer runs; requests ignored
parity_err  output  1  read parity mismatch (see Optional Feature)

Behaviour:
- One clock (clk); synchronous active-high reset (rst). No async logic.
- Reset values: data_out=0, rd_valid=0, busy=1, parity_err=0. State=CLEAR, clear pointer=0. Array contents are not reset directly; the CLEAR state zeroes them.
- States:
  - CLEAR: each cycle writes 0 to array[ptr], then ptr++. When ptr == depth-1 is written, the next state is IDLE. busy=1 throughout. Takes exactly 2**ADDR_WIDTH cycles. busy deasserts on the first cycle in IDLE.
  - IDLE: busy=0; services requests.
- IDLE transitions:
  - clear=1 -> CLEAR with ptr=0. clear has priority over read/write in the same cycle; that read/write is dropped.
  - clear=1 while busy is ignored; the sweep is not restarted.
- Write (IDLE, write=1): array[addr] <= data_in at that posedge. data_out is unchanged and rd_valid=0.
- Read (IDLE, read=1, write=0): data_out <= array[addr] at that posedge; rd_valid=1 for that cycle.
  - Latency: one cycle. Data is stable by the following negedge.
  - data_out holds its value until the next accepted read.
- read=1 and write=1 in the same cycle: the write is performed. data_out <= data_in (write-through); rd_valid=1.
- Read immediately after a write to the same address on the next cycle returns the new data. No read-during-write hazard exists across cycles.
- Requests during busy are dropped. data_out holds, rd_valid=0.
- addr covers the full space; there is no out-of-range case. The sequencer pointer wraps only via the state exit, never mod-depth.
- rst asserted mid-CLEAR or mid-operation restarts CLEAR from ptr=0 on the next cycle. Outputs take their reset values.

Optional Feature:
Macro MEM_RESPONDER_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit, computed from data_in on write and set to 0 during CLEAR.
  - On an accepted read, parity_err <= (stored parity != ^stored data), registered alongside data_out.
  - parity_err is cleared on the next accepted read with good parity, and on rst.
  - Write-through reads set parity_err=0.
- Not defined: no parity storage; parity_err is tied 0. The port list is identical in both builds.

Test Plan:
1. Reset: rst=1 for 2 cycles, then release -> busy=1 for exactly 32 cycles. Reading addresses 0..31 afterwards returns 8'h00, with rd_valid pulsing once per read.
2. Write/read: write addr=5 data=8'hA5, next cycle read addr=5 -> data_out=8'hA5 one posedge later, rd_valid=1 for 1 cycle. data_out holds 8'hA5 through 3 idle cycles.
3. Full sweep: write i to every addr i (0..31), then re-read all -> data_out==i for each. Then clear=1 -> busy 32 cycles, and all re-reads return 0.
4. Simultaneous: read=1, write=1, addr=7, data_in=8'h3C -> data_out=8'h3C, rd_valid=1. A later read of addr 7 returns 8'h3C.
5. Busy/priority: during CLEAR, issue write addr=2 data=8'hFF -> dropped, and addr 2 reads 0 after the sweep. clear+write in the same IDLE cycle -> write dropped, busy=1 next cycle.
6. Reset mid-CLEAR: rst at cycle 10 of the sweep -> busy stays 1 for a full 32 cycles after release. With MEM_RESPONDER_PARITY_EN, a forced parity bit flip on addr 4 -> read sets parity_err=1; the next good read clears it.
